// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding load/store controller between the execute
// stage and a fixed-latency data memory.
//
// Ports:
//   clk, rst_b                    clock, asynchronous active-low reset
//   req_valid/we/addr/wdata       request from the execute stage
//   req_ready                     controller is idle and can accept
//   stall                         freeze request to the core pipeline
//   resp_valid/rdata/err          one-cycle response (err = misaligned)
//   mem_en/we/addr/wdata          memory port, driven during ACCESS only
//   mem_rdata                     memory read data, valid in last ACCESS cycle
//   rd_count, wr_count            saturating counts of aligned loads/stores
module data_mem_ctrl #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    localparam logic [7:0] LatM1 = 8'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] rd_q, rd_d;
    logic [15:0] wr_q, wr_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d = req_we;
                    if (req_addr[1:0] != 2'b00) begin
                        // Misaligned: skip the memory entirely; the memory-side
                        // address/data registers keep their previous values.
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        cnt_d   = LatM1;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (cnt_q == 8'd0) begin
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (!err_q) begin
                    if (we_q) begin
                        if (wr_q != 16'hFFFF) wr_d = wr_q + 16'd1;
                    end else begin
                        if (rd_q != 16'hFFFF) rd_d = rd_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == StIdle);
        stall      = ((state_q == StIdle) && req_valid) || (state_q == StAccess);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !we_q) ? rdata_q : 32'd0;
        mem_en     = (state_q == StAccess);
        mem_we     = mem_en && we_q;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = wdata_q;
        rd_count   = rd_q;
        wr_count   = wr_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int tests = 0;
    int fails = 0;

    data_mem_ctrl #(.MEM_LATENCY(2)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rd_count   (rd_count),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full aligned request with latency 2; returns in the IDLE cycle after RESP.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        rst_b     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_stall0", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_counts", {rd_count, wr_count}, 32'd0);
        req_valid = 1'b1;
        #1;
        check("rst_stall_follows_valid", 32'(stall), 32'd1);
        req_valid = 1'b0;
        step();
        #2 rst_b = 1'b1;
        step();

        // Aligned load 0x10
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0010;
        mem_rdata = 32'h0BAD_0BAD;
        #1;
        check("ld_stall_idle", 32'(stall), 32'd1);
        step();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFF0;
        check("ld_c1_mem_en", 32'(mem_en), 32'd1);
        check("ld_c1_mem_we", 32'(mem_we), 32'd0);
        check("ld_c1_mem_addr", mem_addr, 32'h0000_0010);
        check("ld_c1_ready", 32'(req_ready), 32'd0);
        step();
        mem_rdata = 32'hDEAD_BEEF;
        check("ld_c2_mem_en", 32'(mem_en), 32'd1);
        check("ld_c2_mem_addr", mem_addr, 32'h0000_0010);
        check("ld_c2_resp_valid", 32'(resp_valid), 32'd0);
        step();
        mem_rdata = 32'h0;
        check("ld_c3_resp_valid", 32'(resp_valid), 32'd1);
        check("ld_c3_rdata", resp_rdata, 32'hDEAD_BEEF);
        check("ld_c3_err", 32'(resp_err), 32'd0);
        check("ld_c3_stall", 32'(stall), 32'd0);
        check("ld_c3_mem_en", 32'(mem_en), 32'd0);
        step();
        check("ld_idle_resp_valid", 32'(resp_valid), 32'd0);
        check("ld_rd_count", 32'(rd_count), 32'd1);
        check("ld_mem_addr_hold", mem_addr, 32'h0000_0010);

        // Aligned store 0x20
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'h1234_5678;
        mem_rdata = 32'h5555_AAAA;
        step();
        req_valid = 1'b0;
        req_wdata = 32'hFFFF_FFFF;
        check("st_c1_mem_we", 32'(mem_we), 32'd1);
        check("st_c1_mem_addr", mem_addr, 32'h0000_0020);
        check("st_c1_mem_wdata", mem_wdata, 32'h1234_5678);
        step();
        check("st_c2_mem_we", 32'(mem_we), 32'd1);
        check("st_c2_mem_wdata", mem_wdata, 32'h1234_5678);
        step();
        check("st_resp_valid", 32'(resp_valid), 32'd1);
        check("st_resp_rdata", resp_rdata, 32'd0);
        check("st_mem_we_off", 32'(mem_we), 32'd0);
        step();
        check("st_wr_count", 32'(wr_count), 32'd1);
        check("st_rd_count", 32'(rd_count), 32'd1);
        check("st_wdata_hold", mem_wdata, 32'h1234_5678);

        // Misaligned load 0x13
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0013;
        step();
        req_valid = 1'b0;
        check("mis_resp_valid", 32'(resp_valid), 32'd1);
        check("mis_resp_err", 32'(resp_err), 32'd1);
        check("mis_rdata", resp_rdata, 32'd0);
        check("mis_mem_en", 32'(mem_en), 32'd0);
        check("mis_mem_addr_hold", mem_addr, 32'h0000_0020);
        step();
        check("mis_resp_err_after", 32'(resp_err), 32'd0);
        check("mis_counts", {rd_count, wr_count}, {16'd1, 16'd1});

        // Three back-to-back loads with req_valid held high
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0040;
        mem_rdata = 32'hA5A5_A5A5;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("b2b_resp_valid_%0d", k), 32'(resp_valid), 32'((k % 4) == 3));
            check($sformatf("b2b_stall_%0d", k), 32'(stall), 32'((k % 4) != 3));
            if (k == 11) req_valid = 1'b0;
            step();
        end
        check("b2b_rd_count", 32'(rd_count), 32'd4);

        // Reset in the first ACCESS cycle
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0050;
        step();
        req_valid = 1'b0;
        check("abort_mem_en_before", 32'(mem_en), 32'd1);
        #2 rst_b = 1'b0;
        #1;
        check("abort_mem_en_async", 32'(mem_en), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        step();
        step();
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_counts", {rd_count, wr_count}, 32'd0);
        #2 rst_b = 1'b1;
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0060;
        req_wdata = 32'hCAFE_F00D;
        step();
        req_valid = 1'b0;
        check("post_rst_accept", 32'(mem_en), 32'd1);
        step();
        step();
        check("post_rst_resp", 32'(resp_valid), 32'd1);
        step();
        check("post_rst_wr_count", 32'(wr_count), 32'd1);
        check("post_rst_rd_count", 32'(rd_count), 32'd0);

        // Saturation of wr_count
        force dut.wr_q = 16'hFFFE;
        step();
        release dut.wr_q;
        do_req(1'b1, 32'h0000_0070, 32'h1111_1111);
        check("sat_wr_ffff", 32'(wr_count), 32'h0000_FFFF);
        do_req(1'b1, 32'h0000_0074, 32'h2222_2222);
        check("sat_wr_hold", 32'(wr_count), 32'h0000_FFFF);
        check("sat_rd_untouched", 32'(rd_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: MEM_LATENCY, 2, memory access cycles per request (legal 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  load/store request from the I-type execute stage (its mem_we or load decode).
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address from the execute stage (mem_addr).
REQ-007 req_wdata  input  32  store word from the execute stage (mem_data_out).
REQ-008 req_ready  output  1  controller can accept a request this cycle.
REQ-009 stall  output  1  freeze request to the core pipeline.
REQ-010 resp_valid  output  1  one-cycle response pulse.
REQ-011 resp_rdata  output  32  load data, valid with resp_valid.
REQ-012 resp_err  output  1  misaligned-access flag, valid with resp_valid.
REQ-013 mem_en  output  1  memory enable.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  32  word-aligned memory byte address.
REQ-016 mem_wdata  output  32  memory write data.
REQ-017 mem_rdata  input  32  memory read data, valid in the last ACCESS cycle.
REQ-018 rd_count  output  16  completed aligned loads, saturating.
REQ-019 wr_count  output  16  completed aligned stores, saturating.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP, encoded in 2 bits.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-022 On accept, req_we, req_addr and req_wdata SHALL be captured; later changes on the req_* inputs SHALL be ignored until the next IDLE.
REQ-023 Aligned accept (req_addr[1:0]==0): next state ACCESS, with an 8-bit latency counter loaded to MEM_LATENCY-1.
REQ-024 Misaligned accept: next state RESP directly; mem_en SHALL never assert for that request.
REQ-025 In ACCESS: mem_en=1, and mem_we, mem_addr and mem_wdata SHALL equal the captured values, held constant every cycle.
REQ-026 ACCESS behaviour:
- Counter decrements each cycle.
- When the counter is 0: capture mem_rdata (loads only) and move to RESP.
- ACCESS therefore lasts exactly MEM_LATENCY cycles.
REQ-027 In RESP: resp_valid=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 resp_rdata in RESP:
- Aligned load: captured mem_rdata.
- Store or misaligned access: 0.
REQ-029 resp_err SHALL be 1 in RESP only for a misaligned request.
REQ-030 Latency from the accept edge to resp_valid high SHALL be MEM_LATENCY+1 cycles (aligned) or 1 cycle (misaligned).
REQ-031 stall SHALL equal (IDLE and req_valid) or ACCESS, and SHALL be 0 in RESP so the core advances with the response.
REQ-032 Back-to-back requests: a request held through RESP SHALL be accepted in the following IDLE cycle, at the earliest 1 cycle after RESP.
REQ-033 Outside ACCESS: mem_en=0 and mem_we=0.
- mem_addr and mem_wdata hold their last values.
REQ-034 Counters: rd_count (loads) and wr_count (stores) SHALL increment by 1 in RESP for aligned requests only.
- Each SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-035 While rst_b=0, the following SHALL apply immediately, independent of clk:
- FSM = IDLE; latency counter = 0.
- req_ready=1.
- resp_valid=0, resp_err=0, resp_rdata=0.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- rd_count=0, wr_count=0.
- stall = req_valid.
REQ-036 Reset asserted during ACCESS SHALL abort the access with no response pulse and no counter increment.
REQ-037 After rst_b deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-038 MEM_LATENCY=2; load addr 0x0000_0010, mem_rdata=0xDEAD_BEEF -> mem_en high on cycles 1-2 after accept, resp_valid on cycle 3, resp_rdata=0xDEAD_BEEF, rd_count=1.
REQ-039 Store addr 0x0000_0020, wdata 0x1234_5678 -> mem_we=1 for 2 cycles with addr 0x20 and data 0x1234_5678, resp_rdata=0, wr_count=1.
REQ-040 Load addr 0x0000_0013 -> no mem_en, resp_valid and resp_err=1 one cycle after accept, counters unchanged.
REQ-041 req_valid held high for 3 loads -> resp_valid every 4 cycles, stall=0 only in RESP cycles.
REQ-042 rst_b pulled low in the 1st ACCESS cycle -> mem_en drops without a clock edge, no resp_valid, counters stay 0.
REQ-043 Preload wr_count to 0xFFFE by 2 stores past saturation (or force) -> value stays 0xFFFF after further stores.
